// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC, with a
// strobe watchdog that answers a silent slave with ERR so no master can hang.
module wb_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,

  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          abort_q, abort_d;

  logic              gnt0, gnt1;
  logic              sel_cyc, sel_stb, sel_we;
  logic [SEL_W-1:0]  sel_sel;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_dat;
  logic              stb_live;
  logic              timeout_hit;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // On a tie, last_q names the master served most recently, so the other one wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_sel = '0;
    sel_adr = '0;
    sel_dat = '0;
    if (gnt0) begin
      sel_cyc = m0_cyc_i;
      sel_stb = m0_stb_i;
      sel_we  = m0_we_i;
      sel_sel = m0_sel_i;
      sel_adr = m0_adr_i;
      sel_dat = m0_dat_i;
    end else if (gnt1) begin
      sel_cyc = m1_cyc_i;
      sel_stb = m1_stb_i;
      sel_we  = m1_we_i;
      sel_sel = m1_sel_i;
      sel_adr = m1_adr_i;
      sel_dat = m1_dat_i;
    end
  end

  assign stb_live    = sel_stb & ~abort_q;
  // An ack landing on the expiry cycle wins, so no error is raised for it.
  assign timeout_hit = WD_EN && stb_live && !s_ack_i && (wd_q == WD_MAX);

  assign s_cyc_o = sel_cyc;
  assign s_stb_o = stb_live;
  assign s_we_o  = sel_we;
  assign s_sel_o = sel_sel;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;

  assign m0_ack_o = gnt0 & stb_live & s_ack_i;
  assign m1_ack_o = gnt1 & stb_live & s_ack_i;
  assign m0_err_o = gnt0 & timeout_hit;
  assign m1_err_o = gnt1 & timeout_hit;
  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m1_dat_o = gnt1 ? s_dat_i : '0;
  assign grant_o  = {gnt1, gnt0};

  // Idle clears the watchdog, which covers the clear on grant entry; a gap in
  // stb leaves the count frozen, and abort sticks until the master leaves.
  always_comb begin
    wd_d    = wd_q;
    abort_d = abort_q;
    if (state_q == IDLE) begin
      wd_d    = '0;
      abort_d = 1'b0;
    end else begin
      if (s_ack_i) begin
        wd_d = '0;
      end else if (WD_EN && stb_live && (wd_q != WD_MAX)) begin
        wd_d = wd_q + CW'(1);
      end
      if (timeout_hit) begin
        abort_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

endmodule
